// File: rtl/mem_xbar_n_pkg.sv
// Shared types and default address map for the N-target data crossbar.
// FSM state encoding plus a small width helper.
package mem_xbar_n_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } xbar_state_e;

  localparam logic [29:0] XBAR_DMEM_START = 30'h0000_0000;
  localparam logic [29:0] XBAR_DMEM_LIMIT = 30'h0000_0FFF;
  localparam logic [29:0] XBAR_MMIO_START = 30'h0000_1000;
  localparam logic [29:0] XBAR_MMIO_LIMIT = 30'h0000_10FF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_xbar_n_addr_decode.sv
// Priority address decoder: lowest-index region containing
// the address wins; also yields the region-relative offset.
module mem_xbar_n_addr_decode
  import mem_xbar_n_pkg::*;
#(
  parameter int N_TGT  = 2,
  parameter int ADDR_W = 30,
  parameter int IDX_W  = idx_w(N_TGT),
  parameter logic [N_TGT*ADDR_W-1:0] START = '0,
  parameter logic [N_TGT*ADDR_W-1:0] LIMIT = '0
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx,
  output logic [ADDR_W-1:0] o_offset
);

  // Scan high to low so the lowest matching index overwrites last.
  always_comb begin
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] off;
    o_hit    = 1'b0;
    o_idx    = '0;
    o_offset = '0;
    base     = '0;
    span     = '0;
    off      = '0;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      base = START[i*ADDR_W +: ADDR_W];
      span = LIMIT[i*ADDR_W +: ADDR_W] - base;
      off  = i_addr - base;
      if (off <= span) begin
        o_hit    = 1'b1;
        o_idx    = IDX_W'(i);
        o_offset = off;
      end
    end
  end

endmodule

// File: rtl/mem_xbar_n.sv
// Core data port to N address-decoded targets with wait states,
// one-cycle registered read return and unmapped/timeout errors.
module mem_xbar_n
  import mem_xbar_n_pkg::*;
#(
  parameter int N_TGT  = 2,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter logic [N_TGT*ADDR_W-1:0] TGT_START = '0,
  parameter logic [N_TGT*ADDR_W-1:0] TGT_LIMIT = '0,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [DATA_W-1:0]       i_data,
  input  logic [DATA_W/8-1:0]     i_mask,
  input  logic                    i_wren,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_ready,
  output logic                    o_err,
  output logic [ADDR_W-1:0]       o_tgt_addr,
  output logic [DATA_W-1:0]       o_tgt_data,
  output logic [DATA_W/8-1:0]     o_tgt_mask,
  output logic [N_TGT-1:0]        o_tgt_sel,
  output logic [N_TGT-1:0]        o_tgt_wren,
  input  logic [N_TGT*DATA_W-1:0] i_tgt_data,
  input  logic [N_TGT-1:0]        i_tgt_ready
);

  localparam int IDX_W  = idx_w(N_TGT);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

  xbar_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic [ADDR_W-1:0] dec_off;

  logic              strobe;
  logic              strobe_wr;
  logic [IDX_W-1:0]  use_idx;
  logic [N_TGT-1:0]  onehot;

  mem_xbar_n_addr_decode #(
    .N_TGT  (N_TGT),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W),
    .START  (TGT_START),
    .LIMIT  (TGT_LIMIT)
  ) u_dec (
    .i_addr   (i_addr),
    .o_hit    (dec_hit),
    .o_idx    (dec_idx),
    .o_offset (dec_off)
  );

  assign o_tgt_addr = dec_off;
  assign o_tgt_data = i_data;
  assign o_tgt_mask = i_mask;
  assign onehot     = N_TGT'(1) << use_idx;

  // Next-state, strobe and response logic of the transaction FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    strobe    = 1'b0;
    strobe_wr = 1'b0;
    use_idx   = idx_q;
    o_ready   = 1'b0;
    o_err     = 1'b0;
    o_data    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_req) begin
          if (!dec_hit) begin
            state_d = S_ERR;
          end else begin
            strobe    = 1'b1;
            strobe_wr = i_wren;
            use_idx   = dec_idx;
            idx_d     = dec_idx;
            wr_d      = i_wren;
            cnt_d     = '0;
            if (i_tgt_ready[dec_idx]) begin
              state_d = S_RESP;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (!i_req) begin
          state_d = S_IDLE;
        end else if (TIMEOUT > 0 &&
                     cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          strobe    = 1'b1;
          strobe_wr = wr_q;
          if (i_tgt_ready[idx_q]) begin
            state_d = S_RESP;
          end else if (TIMEOUT > 0) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RESP: begin
        o_ready = 1'b1;
        if (!wr_q) begin
          o_data = i_tgt_data[idx_q*DATA_W +: DATA_W];
        end
        state_d = S_IDLE;
      end
      S_ERR: begin
        o_ready = 1'b1;
        o_err   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are forced low while reset is held, even mid-request.
  always_comb begin
    o_tgt_sel  = '0;
    o_tgt_wren = '0;
    if (strobe && rst_n) begin
      o_tgt_sel = onehot;
      if (strobe_wr) begin
        o_tgt_wren = onehot;
      end
    end
  end

  // State, latched target index, direction and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_xbar_n.sv
// Randomised directed bench for mem_xbar_n against a
// transaction-level model of the address map and wait timing.
module tb_mem_xbar_n;

  localparam int N  = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [N*AW-1:0] ST_P =
    {30'h0800, 30'h1000, 30'h0000};
  localparam logic [N*AW-1:0] LM_P =
    {30'h17FF, 30'h10FF, 30'h0FFF};

  typedef struct packed {
    logic          rdy;
    logic          err;
    logic [DW-1:0] data;
    logic [N-1:0]  sel;
    logic [N-1:0]  wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] tdata;
    logic [3:0]    tmask;
  } obs_t;

  logic [AW-1:0] st [N];
  logic [AW-1:0] lm [N];

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_req = 1'b0;
  logic [AW-1:0]   i_addr = '0;
  logic [DW-1:0]   i_data = '0;
  logic [3:0]      i_mask = '0;
  logic            i_wren = 1'b0;
  logic [DW-1:0]   o_data;
  logic            o_ready;
  logic            o_err;
  logic [AW-1:0]   o_tgt_addr;
  logic [DW-1:0]   o_tgt_data;
  logic [3:0]      o_tgt_mask;
  logic [N-1:0]    o_tgt_sel;
  logic [N-1:0]    o_tgt_wren;
  logic [N*DW-1:0] i_tgt_data = '0;
  logic [N-1:0]    i_tgt_ready = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_xbar_n #(
    .N_TGT     (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TGT_START (ST_P),
    .TGT_LIMIT (LM_P),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .i_mask      (i_mask),
    .i_wren      (i_wren),
    .o_data      (o_data),
    .o_ready     (o_ready),
    .o_err       (o_err),
    .o_tgt_addr  (o_tgt_addr),
    .o_tgt_data  (o_tgt_data),
    .o_tgt_mask  (o_tgt_mask),
    .o_tgt_sel   (o_tgt_sel),
    .o_tgt_wren  (o_tgt_wren),
    .i_tgt_data  (i_tgt_data),
    .i_tgt_ready (i_tgt_ready)
  );

  // First region (lowest index) holding the address, -1 if none.
  function automatic int ref_tgt(input logic [AW-1:0] a);
    for (int i = 0; i < N; i++) begin
      if (a >= st[i] && a <= lm[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] ref_off(input logic [AW-1:0] a);
    int t;
    t = ref_tgt(a);
    if (t < 0) return '0;
    return a - st[t];
  endfunction

  task automatic check(input string tag, input obs_t e);
    obs_t o;
    o.rdy   = o_ready;
    o.err   = o_err;
    o.data  = o_data;
    o.sel   = o_tgt_sel;
    o.wren  = o_tgt_wren;
    o.addr  = o_tgt_addr;
    o.tdata = o_tgt_data;
    o.tmask = o_tgt_mask;
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Expect no strobes and no response on the current inputs.
  task automatic check_quiet(input string tag);
    obs_t e;
    e = '0;
    e.addr  = ref_off(i_addr);
    e.tdata = i_data;
    e.tmask = i_mask;
    check(tag, e);
  endtask

  // One transaction; target ready stays low for 'stall' cycles.
  task automatic run_txn(input logic [AW-1:0] a, input logic wr,
                         input int stall, input string tag);
    int   t;
    obs_t e;
    logic done;
    t      = ref_tgt(a);
    i_req  = 1'b1;
    i_addr = a;
    i_wren = wr;
    i_data = $urandom;
    i_mask = 4'($urandom);
    for (int c = 0; c < TO + 4; c++) begin
      i_tgt_ready = N'($urandom);
      if (t >= 0) i_tgt_ready[t] = (c >= stall);
      i_tgt_data = {$urandom, $urandom, $urandom};
      e = '0;
      e.addr  = ref_off(a);
      e.tdata = i_data;
      e.tmask = i_mask;
      done = 1'b0;
      if (t < 0) begin
        if (c == 1) begin
          e.rdy = 1'b1;
          e.err = 1'b1;
          done  = 1'b1;
        end
      end else if (stall < TO) begin
        if (c <= stall) begin
          e.sel  = N'(1) << t;
          e.wren = wr ? e.sel : '0;
        end else begin
          e.rdy  = 1'b1;
          e.data = wr ? '0 : i_tgt_data[t*DW +: DW];
          done   = 1'b1;
        end
      end else begin
        if (c < TO) begin
          e.sel  = N'(1) << t;
          e.wren = wr ? e.sel : '0;
        end else if (c == TO + 1) begin
          e.rdy = 1'b1;
          e.err = 1'b1;
          done  = 1'b1;
        end
      end
      @(negedge clk);
      check($sformatf("%s c%0d", tag, c), e);
      @(posedge clk);
      #1;
      if (done) break;
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    int            r;
    int            s;
    for (int i = 0; i < N; i++) begin
      st[i] = ST_P[i*AW +: AW];
      lm[i] = LM_P[i*AW +: AW];
    end

    // Reset held with a live write request: nothing may strobe.
    i_req  = 1'b1;
    i_wren = 1'b1;
    i_addr = 30'h0004;
    i_tgt_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    i_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("idle");
    @(posedge clk);
    #1;

    run_txn(30'h0004, 1'b0, 0, "rd_t0");
    run_txn(30'h1002, 1'b1, 0, "wr_t1");
    run_txn(30'h2000, 1'b0, 0, "unmapped");
    run_txn(30'h1004, 1'b0, 3, "stall3");
    run_txn(30'h1005, 1'b1, TO, "timeout");
    run_txn(30'h0010, 1'b0, TO - 1, "last_ready");
    run_txn(30'h1000, 1'b0, 0, "ovl_t1");
    run_txn(30'h0900, 1'b1, 0, "ovl_t0");
    run_txn(30'h1500, 1'b0, 1, "t2_only");
    run_txn(30'h0FFF, 1'b0, 0, "t0_top");
    run_txn(30'h10FF, 1'b1, 0, "t1_top");
    run_txn(30'h17FF, 1'b0, 0, "t2_top");
    run_txn(30'h1800, 1'b1, 0, "t2_above");
    i_req = 1'b0;
    @(negedge clk);
    check_quiet("gap");
    @(posedge clk);
    #1;

    // Core withdraws the request while the target is stalling.
    i_req  = 1'b1;
    i_addr = 30'h1010;
    i_wren = 1'b1;
    i_tgt_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    i_req = 1'b0;
    @(negedge clk);
    check_quiet("abort_drop");
    @(posedge clk);
    #1;
    @(negedge clk);
    check_quiet("abort_after");
    @(posedge clk);
    #1;

    // Reset while waiting, then idle: no write strobe afterwards.
    i_req  = 1'b1;
    i_addr = 30'h1020;
    i_wren = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_quiet("rst_in_wait");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_req = 1'b0;
    i_tgt_ready = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_quiet($sformatf("post_rst%0d", k));
      @(posedge clk);
      #1;
    end

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r == 9) a = AW'($urandom);
      else        a = AW'($urandom_range(0, 'h1FFF));
      r = $urandom_range(0, 9);
      if (r < 5)       s = 0;
      else if (r < 8)  s = $urandom_range(1, 3);
      else if (r == 8) s = TO - 1;
      else             s = TO;
      run_txn(a, 1'($urandom), s, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        i_req = 1'b0;
        @(negedge clk);
        check_quiet($sformatf("rnd_gap%0d", n));
        @(posedge clk);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
